// File: rtl/crossing_counter_param.sv
// Debounced all-zero crossing detector with a wrap/saturate crossing counter,
// target flag and inactivity auto-clear for the line-follower datapath.
module crossing_counter_param #(
   parameter int unsigned NUM_SENSORS    = 3,
   parameter int unsigned CNT_W          = 4,
   parameter int unsigned DEBOUNCE       = 2,
   parameter int unsigned WRAP_MODE      = 0,
   parameter int unsigned PRESET_VAL     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SENSORS-1:0] sensors,
   input  logic                   enable,
   input  logic                   clear,
   input  logic                   preset,
   input  logic [CNT_W-1:0]       target,
   output logic [CNT_W-1:0]       count,
   output logic                   on_crossing,
   output logic                   crossing_pulse,
   output logic                   target_reached,
   output logic                   timeout_pulse
);

   localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_PRESET = CNT_W'(PRESET_VAL);

   typedef enum logic {StIdle, StCross} state_e;

   state_e            state_q;
   logic [DB_W-1:0]   db_q;
   logic [TO_W-1:0]   to_q;
   logic              is_z;
   logic              db_last;
   logic              accept;
   logic              to_run;
   logic              to_fire;
   logic [CNT_W-1:0]  count_inc;

   assign is_z        = ~|sensors;
   assign db_last     = (db_q == DB_LAST);
   assign accept      = enable && (state_q == StIdle) && is_z && db_last;
   // A zero count never times out, so the window only runs while there is something to clear.
   assign to_run      = (TIMEOUT_CYCLES != 0) && enable && (count != '0);
   assign to_fire     = to_run && (to_q == TO_LAST);
   assign count_inc   = ((WRAP_MODE == 0) && (count == CNT_MAX)) ? count : count + 1'b1;
   assign on_crossing = (state_q == StCross);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         db_q           <= '0;
         to_q           <= '0;
         count          <= CNT_PRESET;
         crossing_pulse <= 1'b0;
         target_reached <= 1'b0;
         timeout_pulse  <= 1'b0;
      end else begin
         if (!enable) begin
            state_q <= StIdle;
            db_q    <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (!is_z) begin
                     db_q <= '0;
                  end else if (db_last) begin
                     state_q <= StCross;
                     db_q    <= '0;
                  end else begin
                     db_q <= db_q + 1'b1;
                  end
               end
               StCross: begin
                  if (is_z) begin
                     db_q <= '0;
                  end else if (db_last) begin
                     state_q <= StIdle;
                     db_q    <= '0;
                  end else begin
                     db_q <= db_q + 1'b1;
                  end
               end
            endcase
         end

         crossing_pulse <= 1'b0;
         target_reached <= 1'b0;
         timeout_pulse  <= 1'b0;
         // Count priority: preset > clear > timeout > increment; the FSM above advances regardless.
         if (preset) begin
            count <= CNT_PRESET;
            to_q  <= '0;
         end else if (clear) begin
            count <= '0;
            to_q  <= '0;
         end else if (to_fire) begin
            count         <= '0;
            to_q          <= '0;
            timeout_pulse <= 1'b1;
         end else if (accept) begin
            count          <= count_inc;
            to_q           <= '0;
            crossing_pulse <= 1'b1;
            target_reached <= (count_inc == target);
         end else if (to_run) begin
            to_q <= to_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_crossing_counter_param.sv
// Bench for crossing_counter_param: six parameter sets driven in parallel, checked against
// vector tables, hand sequences and a run-length/arithmetic reference model.
module tb_crossing_counter_param;

   localparam int NK = 6;
   localparam int P_NS [NK] = '{3, 3, 3, 3, 4, 2};
   localparam int P_CW [NK] = '{4, 2, 2, 4, 3, 3};
   localparam int P_DB [NK] = '{2, 2, 2, 2, 3, 1};
   localparam int P_WR [NK] = '{0, 1, 0, 0, 1, 0};
   localparam int P_PR [NK] = '{1, 1, 1, 1, 5, 0};
   localparam int P_TO [NK] = '{1000000, 0, 0, 20, 7, 5};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, enable, clear, preset;
   logic [3:0] sensors, target;
   logic [3:0] cnt_w [NK];
   logic       on_w [NK];
   logic       cp_w [NK];
   logic       tr_w [NK];
   logic       tp_w [NK];

   for (genvar g = 0; g < NK; g++) begin : g_dut
      logic [P_CW[g]-1:0] cnt;
      crossing_counter_param #(
         .NUM_SENSORS   (P_NS[g]),
         .CNT_W         (P_CW[g]),
         .DEBOUNCE      (P_DB[g]),
         .WRAP_MODE     (P_WR[g]),
         .PRESET_VAL    (P_PR[g]),
         .TIMEOUT_CYCLES(P_TO[g])
      ) u_dut (
         .clk           (clk),
         .reset         (reset),
         .sensors       (sensors[P_NS[g]-1:0]),
         .enable        (enable),
         .clear         (clear),
         .preset        (preset),
         .target        (target[P_CW[g]-1:0]),
         .count         (cnt),
         .on_crossing   (on_w[g]),
         .crossing_pulse(cp_w[g]),
         .target_reached(tr_w[g]),
         .timeout_pulse (tp_w[g])
      );
      assign cnt_w[g] = 4'(cnt);
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: run = consecutive samples of the class that would leave the
   // current state, idle = cycles elapsed since the count last changed by an event.
   int m_cnt  [NK];
   bit m_in   [NK];
   int m_run  [NK];
   int m_idle [NK];
   bit m_cp   [NK];
   bit m_tr   [NK];
   bit m_tp   [NK];

   typedef struct {
      logic [3:0] sens;
      int         en, clr, pre;
      logic [3:0] tgt;
      int         rep;
      int         ecnt, eon, ecp, etr;
   } vec_t;

   vec_t tbl [25];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < NK; k++) begin
         int mask, maxv;
         bit z, took, fired;
         mask  = (1 << P_NS[k]) - 1;
         maxv  = (1 << P_CW[k]) - 1;
         z     = ((int'(sensors) & mask) == 0);
         took  = 1'b0;
         if (reset) begin
            m_cnt[k]  = P_PR[k];
            m_in[k]   = 1'b0;
            m_run[k]  = 0;
            m_idle[k] = 0;
            m_cp[k]   = 1'b0;
            m_tr[k]   = 1'b0;
            m_tp[k]   = 1'b0;
         end else begin
            if (!enable) begin
               m_in[k]  = 1'b0;
               m_run[k] = 0;
            end else begin
               // Outside a crossing Z is sought; inside, NZ is sought.
               if (z != m_in[k]) m_run[k]++;
               else m_run[k] = 0;
               if (m_run[k] == P_DB[k]) begin
                  took     = !m_in[k];
                  m_in[k]  = !m_in[k];
                  m_run[k] = 0;
               end
            end
            fired   = (P_TO[k] != 0) && enable && (m_cnt[k] != 0) && (m_idle[k] == P_TO[k] - 1);
            m_cp[k] = 1'b0;
            m_tr[k] = 1'b0;
            m_tp[k] = 1'b0;
            if (preset) begin
               m_cnt[k]  = P_PR[k];
               m_idle[k] = 0;
            end else if (clear) begin
               m_cnt[k]  = 0;
               m_idle[k] = 0;
            end else if (fired) begin
               m_cnt[k]  = 0;
               m_idle[k] = 0;
               m_tp[k]   = 1'b1;
            end else if (took) begin
               if (P_WR[k] != 0) m_cnt[k] = (m_cnt[k] + 1) % (maxv + 1);
               else if (m_cnt[k] < maxv) m_cnt[k] = m_cnt[k] + 1;
               m_idle[k] = 0;
               m_cp[k]   = 1'b1;
               m_tr[k]   = (m_cnt[k] == (int'(target) & maxv));
            end else if ((P_TO[k] != 0) && enable && (m_cnt[k] != 0)) begin
               m_idle[k]++;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      for (int k = 0; k < NK; k++) begin
         check($sformatf("model k%0d {cnt,on,cp,tr,tp}", k),
               int'(cnt_w[k]) * 16 + int'(on_w[k]) * 8 + int'(cp_w[k]) * 4 +
               int'(tr_w[k]) * 2 + int'(tp_w[k]),
               m_cnt[k] * 16 + int'(m_in[k]) * 8 + int'(m_cp[k]) * 4 +
               int'(m_tr[k]) * 2 + int'(m_tp[k]));
      end
   endtask

   task automatic z2();
      sensors = 4'h0;
      tick();
      tick();
   endtask

   task automatic nz2();
      sensors = 4'hF;
      tick();
      tick();
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      sensors = 4'hF;
      enable  = 1'b1;
      clear   = 1'b0;
      preset  = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold;
      //            sens     en clr pre tgt  rep cnt on cp tr
      tbl[0]  = '{4'b0000, 1, 0, 0, 4'hF, 1,  1, 0, 0, 0};
      tbl[1]  = '{4'b0101, 1, 0, 0, 4'hF, 1,  1, 0, 0, 0};
      tbl[2]  = '{4'b0000, 1, 0, 0, 4'hF, 1,  1, 0, 0, 0};
      tbl[3]  = '{4'b0000, 1, 0, 0, 4'hF, 1,  2, 1, 1, 0};
      tbl[4]  = '{4'b0000, 1, 0, 0, 4'hF, 50, 2, 1, 0, 0};
      tbl[5]  = '{4'b0010, 1, 0, 0, 4'hF, 1,  2, 1, 0, 0};
      tbl[6]  = '{4'b0010, 1, 0, 0, 4'hF, 1,  2, 0, 0, 0};
      tbl[7]  = '{4'b0000, 1, 0, 0, 4'h3, 1,  2, 0, 0, 0};
      tbl[8]  = '{4'b0000, 1, 0, 0, 4'h3, 1,  3, 1, 1, 1};
      tbl[9]  = '{4'b0111, 1, 0, 0, 4'h3, 1,  3, 1, 0, 0};
      tbl[10] = '{4'b0111, 1, 0, 0, 4'h3, 1,  3, 0, 0, 0};
      tbl[11] = '{4'b0000, 1, 0, 0, 4'h3, 2,  4, 1, 1, 0};
      tbl[12] = '{4'b0110, 1, 0, 0, 4'h3, 2,  4, 0, 0, 0};
      tbl[13] = '{4'b0000, 1, 0, 0, 4'h3, 1,  4, 0, 0, 0};
      tbl[14] = '{4'b0000, 1, 1, 0, 4'h3, 1,  0, 1, 0, 0};
      tbl[15] = '{4'b0011, 1, 0, 0, 4'h3, 2,  0, 0, 0, 0};
      tbl[16] = '{4'b0011, 1, 1, 1, 4'h3, 1,  1, 0, 0, 0};
      tbl[17] = '{4'b0000, 1, 0, 0, 4'h3, 2,  2, 1, 1, 0};
      tbl[18] = '{4'b0000, 0, 0, 0, 4'h3, 1,  2, 0, 0, 0};
      tbl[19] = '{4'b0000, 1, 0, 0, 4'h3, 1,  2, 0, 0, 0};
      tbl[20] = '{4'b0000, 1, 0, 0, 4'h3, 1,  3, 1, 1, 1};
      tbl[21] = '{4'b0100, 1, 0, 0, 4'h3, 2,  3, 0, 0, 0};
      tbl[22] = '{4'b0000, 1, 0, 0, 4'h1, 1,  3, 0, 0, 0};
      tbl[23] = '{4'b0000, 1, 0, 1, 4'h1, 1,  1, 1, 0, 0};
      tbl[24] = '{4'b0101, 1, 0, 0, 4'h1, 2,  1, 0, 0, 0};

      target = 4'hF;
      do_reset();
      check("reset k0 count", int'(cnt_w[0]), 1);
      check("reset k0 on_crossing", int'(on_w[0]), 0);

      // Default-parameter vector table on instance k0.
      for (int i = 0; i < 25; i++) begin
         sensors = tbl[i].sens;
         enable  = (tbl[i].en != 0);
         clear   = (tbl[i].clr != 0);
         preset  = (tbl[i].pre != 0);
         target  = tbl[i].tgt;
         repeat (tbl[i].rep) tick();
         check($sformatf("tbl[%0d] count", i), int'(cnt_w[0]), tbl[i].ecnt);
         check($sformatf("tbl[%0d] on_crossing", i), int'(on_w[0]), tbl[i].eon);
         check($sformatf("tbl[%0d] crossing_pulse", i), int'(cp_w[0]), tbl[i].ecp);
         check($sformatf("tbl[%0d] target_reached", i), int'(tr_w[0]), tbl[i].etr);
      end
      clear  = 1'b0;
      preset = 1'b0;
      target = 4'hF;

      // Wrap (k1) versus saturate (k2) with a 2-bit counter.
      do_reset();
      z2(); nz2(); z2(); nz2();
      check("wrap k1 count before", int'(cnt_w[1]), 3);
      check("sat k2 count before", int'(cnt_w[2]), 3);
      z2();
      check("wrap k1 count", int'(cnt_w[1]), 0);
      check("wrap k1 crossing_pulse", int'(cp_w[1]), 1);
      check("sat k2 count", int'(cnt_w[2]), 3);
      check("sat k2 crossing_pulse", int'(cp_w[2]), 1);
      nz2();

      // Reset values everywhere, then timeout on k3 (20 cycles).
      do_reset();
      for (int k = 0; k < NK; k++) begin
         check($sformatf("reset k%0d count", k), int'(cnt_w[k]), P_PR[k]);
         check($sformatf("reset k%0d outputs", k),
               int'(on_w[k]) + int'(cp_w[k]) + int'(tr_w[k]) + int'(tp_w[k]), 0);
      end
      z2();
      check("timeout k3 count 2", int'(cnt_w[3]), 2);
      sensors = 4'hF;
      repeat (19) tick();
      check("timeout k3 count held", int'(cnt_w[3]), 2);
      check("timeout k3 no early pulse", int'(tp_w[3]), 0);
      tick();
      check("timeout k3 count cleared", int'(cnt_w[3]), 0);
      check("timeout k3 pulse", int'(tp_w[3]), 1);
      tick();
      check("timeout k3 pulse width", int'(tp_w[3]), 0);
      for (int i = 0; i < 40; i++) begin
         tick();
         check("timeout k3 none at zero", int'(tp_w[3]), 0);
      end
      preset = 1'b1;
      tick();
      preset = 1'b0;
      check("timeout k3 preset", int'(cnt_w[3]), 1);
      repeat (13) tick();
      z2();
      check("timeout k3 crossing at 15", int'(cnt_w[3]), 2);
      sensors = 4'hF;
      repeat (19) tick();
      check("timeout k3 window restarted", int'(cnt_w[3]), 2);
      tick();
      check("timeout k3 late count", int'(cnt_w[3]), 0);
      check("timeout k3 late pulse", int'(tp_w[3]), 1);

      // Reset in the middle of a debounce run.
      do_reset();
      sensors = 4'h0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid-db reset count", int'(cnt_w[0]), 1);
      check("mid-db reset on_crossing", int'(on_w[0]), 0);
      tick();
      check("mid-db db cleared", int'(cnt_w[0]), 1);
      tick();
      check("mid-db crossing after reset", int'(cnt_w[0]), 2);
      check("mid-db on_crossing", int'(on_w[0]), 1);

      // Randomized run checked every cycle against the model.
      hold = 0;
      for (int c = 0; c < 3000 && n_fail < 100; c++) begin
         if (hold == 0) begin
            sensors = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            hold    = $urandom_range(1, 8);
         end
         hold--;
         enable = ($urandom_range(0, 49) != 0);
         clear  = ($urandom_range(0, 59) == 0);
         preset = ($urandom_range(0, 59) == 0);
         reset  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) target = 4'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
